// File: rtl/mult_sched.sv
// mult_sched: issue scheduler for the register/multiply datapath.
// Accepts rd <- rs1*rs2 commands, drives the register read ports, tracks ops
// through the fixed read+multiply latency and writes results back. A host
// writer shares the write port, and a scoreboard blocks RAW/WAW hazards.
module mult_sched #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MULT_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [ADDR_W-1:0]                           cmd_rs1,
    input  logic [ADDR_W-1:0]                           cmd_rs2,
    input  logic [ADDR_W-1:0]                           cmd_rd,
    input  logic                                        host_w_valid,
    output logic                                        host_w_ready,
    input  logic [ADDR_W-1:0]                           host_w_addr,
    input  logic [DATA_W-1:0]                           host_w_data,
    output logic                                        r_valid1,
    output logic                                        r_valid2,
    output logic [ADDR_W-1:0]                           r_addr1,
    output logic [ADDR_W-1:0]                           r_addr2,
    output logic                                        w_valid,
    output logic [ADDR_W-1:0]                           w_addr,
    output logic [DATA_W-1:0]                           w_data,
    input  logic [DATA_W-1:0]                           mult_res,
    input  logic                                        drain_req,
    output logic                                        idle,
    output logic [$clog2(RD_LAT+MULT_LAT+1)-1:0]        inflight,
    output logic [CNT_W-1:0]                            ops_done
);

    localparam int unsigned L    = RD_LAT + MULT_LAT;
    localparam int unsigned IF_W = $clog2(L + 1);
    localparam int unsigned NREG = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [L-1:0]      r_pipe_v;
    logic [ADDR_W-1:0] r_pipe_rd [L];
    logic [NREG-1:0]   r_pending;
    logic [IF_W-1:0]   r_inflight;
    logic [CNT_W-1:0]  r_ops_done;

    logic              w_issue;
    logic              w_wb;
    logic [ADDR_W-1:0] w_wb_rd;
    logic              w_host_grant;
    logic [IF_W-1:0]   w_inflight_nxt;

    // The oldest tracked op reaches writeback when it leaves the last stage
    assign w_wb    = r_pipe_v[L-1];
    assign w_wb_rd = r_pipe_rd[L-1];

    // Issue only from RUN, and only when no source/destination is pending
    assign cmd_ready    = !rst && (r_state == ST_RUN) && !r_pending[cmd_rs1]
                          && !r_pending[cmd_rs2] && !r_pending[cmd_rd];
    assign w_issue      = cmd_valid && cmd_ready;

    // Pipe writeback owns the write port; host waits on busy or pending target
    assign host_w_ready = !rst && !w_wb && !r_pending[host_w_addr];
    assign w_host_grant = host_w_valid && host_w_ready;

    assign idle     = (r_state != ST_DRAIN) && (r_inflight == '0);
    assign inflight = r_inflight;
    assign ops_done = r_ops_done;

    // Read-port drive and write-port mux
    always_comb begin
        r_valid1 = 1'b0;
        r_valid2 = 1'b0;
        r_addr1  = '0;
        r_addr2  = '0;
        w_valid  = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        if (w_issue) begin
            r_valid1 = 1'b1;
            r_valid2 = 1'b1;
            r_addr1  = cmd_rs1;
            r_addr2  = cmd_rs2;
        end
        if (w_wb) begin
            w_valid = 1'b1;
            w_addr  = w_wb_rd;
            w_data  = mult_res;
        end else if (w_host_grant) begin
            w_valid = 1'b1;
            w_addr  = host_w_addr;
            w_data  = host_w_data;
        end
    end

    // In-flight count after this cycle's issue/writeback
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_issue && !w_wb) begin
            w_inflight_nxt = r_inflight + IF_W'(1);
        end else if (!w_issue && w_wb) begin
            w_inflight_nxt = r_inflight - IF_W'(1);
        end
    end

    // Drain FSM next state; HALT is entered as soon as the last op retires
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (drain_req) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)                 w_state_nxt = ST_RUN;
                else if (w_inflight_nxt == '0)  w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (!drain_req) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Latency-tracking pipe of {valid, rd}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_v <= '0;
            for (int unsigned i = 0; i < L; i++) r_pipe_rd[i] <= '0;
        end else begin
            r_pipe_v     <= {r_pipe_v[L-2:0], w_issue};
            r_pipe_rd[0] <= cmd_rd;
            for (int unsigned i = 1; i < L; i++) r_pipe_rd[i] <= r_pipe_rd[i-1];
        end
    end

    // Scoreboard: set on issue, cleared on writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (w_wb)    r_pending[w_wb_rd] <= 1'b0;
            if (w_issue) r_pending[cmd_rd]  <= 1'b1;
        end
    end

    // In-flight and completed-op counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
            r_ops_done <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (w_wb) r_ops_done <= r_ops_done + CNT_W'(1);
        end
    end

endmodule
